// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 framebuffer write path.
//   fw_state_t   : frame writer FSM states
//   DEF_*        : default panel geometry / pixel width
//   frame_pixels : pixels per frame for a given geometry
package hub75_pkg;

  typedef enum logic [1:0] {
    DISCARD   = 2'd0,
    WRITING   = 2'd1,
    WAIT_SWAP = 2'd2
  } fw_state_t;

  localparam int DEF_BITS_PER_PIXEL = 12;
  localparam int DEF_PANEL_WIDTH    = 64;
  localparam int DEF_PANEL_HEIGHT   = 32;

  function automatic int frame_pixels(input int width, input int height);
    return width * height;
  endfunction

endpackage

// File: rtl/pixel_strobe_detect.sv
// Rising-edge detector for the spi_slave word marker.
//   spi_clk   : clock
//   reset     : asynchronous, active-high
//   pixel_clk : word marker from spi_slave
//   strobe    : high for the cycle in which pixel_clk is high but was low last cycle
module pixel_strobe_detect (
  input  logic spi_clk,
  input  logic reset,
  input  logic pixel_clk,
  output logic strobe
);

  logic pixel_clk_d;

  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) pixel_clk_d <= 1'b0;
    else       pixel_clk_d <= pixel_clk;
  end

  assign strobe = pixel_clk & ~pixel_clk_d;

endmodule

// File: rtl/spi_frame_writer.sv
// Writes pixel words from spi_slave into a double-banked HUB75 framebuffer.
// The first word after reset is dropped (spi_slave emits rubbish then), later
// words are written row-major; a full frame parks in WAIT_SWAP until the
// display side releases the other bank with swap_done.
//   reset          : asynchronous, active-high
//   spi_clk        : clock
//   pixel_data     : pixel word from spi_slave
//   pixel_clk      : word marker, rising edge = new word
//   swap_done      : one-cycle pulse, display has taken the written bank
//   fb_write_addr  : y*PANEL_WIDTH + x, held when not writing
//   fb_write_data  : pixel being written
//   fb_write_en    : one-cycle write strobe (RAM must qualify with it)
//   fb_write_bank  : bank being written
//   frame_ready    : complete frame waiting for swap
//   overrun_count  : saturating count of words dropped in WAIT_SWAP
module spi_frame_writer
  import hub75_pkg::*;
#(
  parameter int BITS_PER_PIXEL = DEF_BITS_PER_PIXEL,
  parameter int PANEL_WIDTH    = DEF_PANEL_WIDTH,
  parameter int PANEL_HEIGHT   = DEF_PANEL_HEIGHT,
  parameter int ADDR_BITS      = 11  // 2**ADDR_BITS must cover one frame
) (
  input  logic                      reset,
  input  logic                      spi_clk,
  input  logic [BITS_PER_PIXEL-1:0] pixel_data,
  input  logic                      pixel_clk,
  input  logic                      swap_done,
  output logic [ADDR_BITS-1:0]      fb_write_addr,
  output logic [BITS_PER_PIXEL-1:0] fb_write_data,
  output logic                      fb_write_en,
  output logic                      fb_write_bank,
  output logic                      frame_ready,
  output logic [7:0]                overrun_count
);

  localparam int                   FRAME_PIXELS = frame_pixels(PANEL_WIDTH, PANEL_HEIGHT);
  localparam logic [ADDR_BITS-1:0] LAST_IDX     = ADDR_BITS'(FRAME_PIXELS - 1);

  fw_state_t            state;
  logic [ADDR_BITS-1:0] pixel_idx;
  logic                 strobe;

  pixel_strobe_detect u_strobe (
    .spi_clk   (spi_clk),
    .reset     (reset),
    .pixel_clk (pixel_clk),
    .strobe    (strobe)
  );

  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      state         <= DISCARD;
      pixel_idx     <= '0;
      fb_write_addr <= '0;
      fb_write_data <= '0;
      fb_write_en   <= 1'b0;
      fb_write_bank <= 1'b0;
      frame_ready   <= 1'b0;
      overrun_count <= 8'd0;
    end else begin
      fb_write_en <= 1'b0;
      case (state)
        DISCARD: begin
          if (strobe) state <= WRITING;
        end
        // swap_done is deliberately ignored here: the display cannot own
        // a bank we have not finished.
        WRITING: begin
          if (strobe) begin
            fb_write_en   <= 1'b1;
            fb_write_data <= pixel_data;
            fb_write_addr <= pixel_idx;
            if (pixel_idx == LAST_IDX) begin
              pixel_idx   <= '0;
              frame_ready <= 1'b1;
              state       <= WAIT_SWAP;
            end else begin
              pixel_idx <= pixel_idx + ADDR_BITS'(1);
            end
          end
        end
        // A strobe coinciding with swap_done is still dropped: the word
        // belongs to the dummy stream the host clocks to carry the swap.
        WAIT_SWAP: begin
          if (strobe && overrun_count != 8'hFF)
            overrun_count <= overrun_count + 8'd1;
          if (swap_done) begin
            fb_write_bank <= ~fb_write_bank;
            frame_ready   <= 1'b0;
            state         <= WRITING;
          end
        end
        default: state <= DISCARD;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_writer.sv
module tb_spi_frame_writer;

  localparam int BPP  = 12;
  localparam int AW   = 11;
  localparam int LAST = 64 * 32 - 1;

  logic          reset, spi_clk, pixel_clk, swap_done;
  logic [BPP-1:0] pixel_data;
  logic [AW-1:0]  fb_write_addr;
  logic [BPP-1:0] fb_write_data;
  logic           fb_write_en, fb_write_bank, frame_ready;
  logic [7:0]     overrun_count;

  spi_frame_writer #(.BITS_PER_PIXEL(BPP), .PANEL_WIDTH(64), .PANEL_HEIGHT(32), .ADDR_BITS(AW)) dut (
    .reset(reset), .spi_clk(spi_clk), .pixel_data(pixel_data), .pixel_clk(pixel_clk),
    .swap_done(swap_done), .fb_write_addr(fb_write_addr), .fb_write_data(fb_write_data),
    .fb_write_en(fb_write_en), .fb_write_bank(fb_write_bank), .frame_ready(frame_ready),
    .overrun_count(overrun_count)
  );

  initial spi_clk = 1'b0;
  always #5 spi_clk = ~spi_clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // expected write: {addr, data, bank, frame_ready} plus the cycle it must appear in
  typedef struct { logic [31:0] pkt; int at; } wr_t;
  wr_t sb[$];

  // reference model
  int   m_state = 0;   // 0 discard, 1 writing, 2 wait swap
  int   m_idx   = 0;
  logic m_bank  = 1'b0;
  logic m_ready = 1'b0;
  int   m_ovr   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pack(input int a, input logic [BPP-1:0] d, input logic b, input logic r);
    return {7'd0, AW'(a), d, b, r};
  endfunction

  // Scoreboard side: every observed write must match the queue head in content and cycle.
  task automatic sample();
    wr_t e;
    if (sb.size() != 0 && sb[0].at < cyc) begin
      e = sb.pop_front();
      chk("missing_write", 32'd0, e.pkt);
    end
    if (fb_write_en) begin
      if (sb.size() == 0) chk("unexpected_write", {21'd0, fb_write_addr}, 32'hFFFF_FFFF);
      else begin
        e = sb.pop_front();
        chk("write", pack(int'(fb_write_addr), fb_write_data, fb_write_bank, frame_ready), e.pkt);
        chk("write_cycle", cyc, e.at);
      end
    end
  endtask

  task automatic tick();
    @(posedge spi_clk);
    cyc++;
    #1;
    sample();
  endtask

  task automatic model_reset();
    m_state = 0; m_idx = 0; m_bank = 1'b0; m_ready = 1'b0; m_ovr = 0;
    sb.delete();
  endtask

  // One word from spi_slave; sw puts swap_done on the strobe cycle.
  task automatic word(input logic [BPP-1:0] d, input bit sw);
    wr_t e;
    case (m_state)
      0: m_state = 1;
      1: begin
        e.pkt = pack(m_idx, d, m_bank, (m_idx == LAST));
        e.at  = cyc + 1;
        sb.push_back(e);
        if (m_idx == LAST) begin m_idx = 0; m_ready = 1'b1; m_state = 2; end
        else m_idx++;
      end
      default: begin
        if (m_ovr < 255) m_ovr++;
        if (sw) begin m_bank = ~m_bank; m_ready = 1'b0; m_state = 1; end
      end
    endcase
    pixel_data = d; pixel_clk = 1'b1; swap_done = sw;
    tick();
    swap_done = 1'b0;
    tick();
    pixel_clk = 1'b0;
    tick();
    tick();
  endtask

  task automatic swap_pulse();
    if (m_state == 2) begin m_bank = ~m_bank; m_ready = 1'b0; m_state = 1; end
    swap_done = 1'b1;
    tick();
    swap_done = 1'b0;
    tick();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_ready"}, frame_ready, m_ready);
    chk({tag, "_bank"},  fb_write_bank, m_bank);
    chk({tag, "_ovr"},   overrun_count, m_ovr);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic fill_frame(input bit with_swaps);
    while (m_state == 1) begin
      word(BPP'($urandom), with_swaps && (m_idx % 97 == 5 || m_idx == LAST));
      if (with_swaps && m_idx % 211 == 7) swap_pulse();
    end
  endtask

  typedef struct {
    logic [BPP-1:0] data;
    logic [AW-1:0]  exp_addr;
    logic [BPP-1:0] exp_data;
    logic           exp_bank;
  } vec_t;
  vec_t vecs[3];

  initial begin
    vecs[0] = '{12'h111, 11'd0, 12'h000, 1'b0};  // discarded
    vecs[1] = '{12'h222, 11'd0, 12'h222, 1'b0};
    vecs[2] = '{12'h333, 11'd1, 12'h333, 1'b0};

    reset = 1'b1; pixel_clk = 1'b0; swap_done = 1'b0; pixel_data = '0;
    tick(); tick();
    reset = 1'b0;
    model_reset();
    tick();
    chk("reset_outputs", {fb_write_addr, fb_write_data, fb_write_en, fb_write_bank, frame_ready, overrun_count}, 32'd0);

    // first word dropped, then row-major writes
    for (int i = 0; i < 3; i++) begin
      word(vecs[i].data, 1'b0);
      chk($sformatf("vec%0d", i), {fb_write_addr, fb_write_data, fb_write_bank},
          {vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_bank});
    end

    // rest of frame 0
    fill_frame(1'b0);
    chk("frame0_last_addr", fb_write_addr, LAST);
    chk("frame0_ready", frame_ready, 1'b1);
    chk_model("frame0");

    // dummy words while parked
    for (int i = 0; i < 10; i++) word(12'hABC, 1'b0);
    chk("ovr_10", overrun_count, 8'd10);

    // swap coincident with strobe: word counted, swap taken
    word(12'h5A5, 1'b1);
    chk("coinc_ovr", overrun_count, 8'd11);
    chk("coinc_bank", fb_write_bank, 1'b1);
    chk("coinc_ready", frame_ready, 1'b0);
    word(12'h777, 1'b0);
    chk("bank1_first", {fb_write_addr, fb_write_data, fb_write_bank}, {11'd0, 12'h777, 1'b1});

    // swap_done during WRITING (incl. last-pixel strobe) must be ignored
    fill_frame(1'b1);
    chk("frame1_bank", fb_write_bank, 1'b1);
    chk("frame1_ready", frame_ready, 1'b1);
    chk_model("frame1");

    // saturation while parked
    for (int i = 0; i < 300; i++) word(BPP'(i), 1'b0);
    chk("ovr_sat", overrun_count, 8'd255);
    chk("park_addr_held", fb_write_addr, LAST);
    chk_model("sat");

    swap_pulse();
    chk("swap_bank0", fb_write_bank, 1'b0);
    fill_frame(1'b0);
    chk_model("frame2");
    swap_pulse();
    chk("swap_bank1", fb_write_bank, 1'b1);
    chk("ovr_held", overrun_count, 8'd255);

    // 100 writes in bank 1, then asynchronous reset mid-frame
    for (int i = 0; i < 100; i++) word(BPP'(i + 1), 1'b0);
    chk("pre_reset_addr", fb_write_addr, 11'd99);
    @(negedge spi_clk);
    reset = 1'b1;
    #1;
    chk("async_reset", {fb_write_addr, fb_write_data, fb_write_en, fb_write_bank, frame_ready, overrun_count}, 32'd0);
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    word(12'hDEA, 1'b0);
    chk("post_reset_discard", {fb_write_addr, fb_write_data, fb_write_bank}, 24'd0);
    word(12'h456, 1'b0);
    chk("post_reset_write", {fb_write_addr, fb_write_data, fb_write_bank}, {11'd0, 12'h456, 1'b0});
    tick(); tick();
    chk_model("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_frame_writer.md
Name: spi_frame_writer

Overview:
Sequences pixel words from the SPI slave into a double-banked HUB75 framebuffer. Discards the first (invalid) word after reset, then generates row-major write addresses, write enables and a bank select. Parks the frame when complete and waits for the display side to release the other bank. Sits between spi_slave and the framebuffer RAM write port, entirely in the spi_clk domain.

Parameters:
BITS_PER_PIXEL, 12, pixel word width; matches spi_slave data output.
PANEL_WIDTH, 64, pixels per row.
PANEL_HEIGHT, 32, rows per frame.
ADDR_BITS, 11, framebuffer address width per bank; must satisfy 2**ADDR_BITS >= PANEL_WIDTH*PANEL_HEIGHT.

Ports:
reset  in  1  asynchronous, active-high
spi_clk  in  1  clock; SPI serial clock
pixel_data  in  BITS_PER_PIXEL  pixel word from spi_slave
pixel_clk  in  1  spi_slave word marker; rising edge (registered on spi_clk) = new word valid
swap_done  in  1  one-cycle pulse, already synchronised to spi_clk: display has taken the written bank
fb_write_addr  out  ADDR_BITS  framebuffer address, y*PANEL_WIDTH + x
fb_write_data  out  BITS_PER_PIXEL  pixel to write
fb_write_en  out  1  one-cycle write strobe
fb_write_bank  out  1  bank being written
frame_ready  out  1  high while a complete frame awaits swap
overrun_count  out  8  saturating count of words dropped while frame_ready

Behaviour:
- Reset is asynchronous, active-high, clocked by spi_clk. Reset values: state DISCARD, fb_write_addr 0, fb_write_data 0, fb_write_en 0, fb_write_bank 0, frame_ready 0, overrun_count 0, pixel_clk_d 0.
- strobe = pixel_clk & ~pixel_clk_d, where pixel_clk_d is pixel_clk registered on spi_clk. At most one strobe per 32 spi_clk cycles.
- DISCARD: the first strobe goes to WRITING with no write; all outputs are held.
- WRITING, on strobe:
  - Next edge: fb_write_en=1 for exactly one cycle; fb_write_data=pixel_data captured on that strobe edge; fb_write_addr=current pixel index. Latency is one spi_clk edge from strobe.
  - The address counter advances after each write.
  - If the index written was PANEL_WIDTH*PANEL_HEIGHT-1: the counter wraps to 0, the state goes to WAIT_SWAP, and frame_ready=1 from the same edge as that write.
- WRITING: swap_done is ignored, including when it coincides with the last-pixel strobe.
- WAIT_SWAP, on strobe: no write; overrun_count increments and saturates at 255.
- WAIT_SWAP, on swap_done: fb_write_bank toggles, frame_ready=0, state goes to WRITING, next write lands at address 0.
- WAIT_SWAP, strobe and swap_done in the same cycle: the word is dropped and counted, and the swap still takes effect.
- overrun_count is cleared only by reset.
- fb_write_addr holds its last value when fb_write_en=0. The RAM must qualify writes with fb_write_en.
- spi_clk runs only during transfers. swap_done is seen only while the host is clocking, so the host clocks dummy words after a frame; these are counted as overruns.
- Reset mid-frame: the partial frame is abandoned, the bank returns to 0, and the next strobe is discarded again, matching spi_slave's post-reset rubbish word.
- Address arithmetic is unsigned at ADDR_BITS width. The frame-size compare uses a localparam FRAME_PIXELS = PANEL_WIDTH*PANEL_HEIGHT.

Decomposition:
- Shared package hub75_pkg:
  - state enum {DISCARD, WRITING, WAIT_SWAP}
  - default PANEL_WIDTH, PANEL_HEIGHT, BITS_PER_PIXEL constants
  - FRAME_PIXELS helper
- One natural sub-module: pixel_strobe_detect, covering the pixel_clk_d register and the rising-edge pulse. The address counter, FSM and overrun counter stay in spi_frame_writer.

Test Plan:
1. Reset, then 3 strobes with pixel_data 0x111, 0x222, 0x333 -> first word discarded; writes addr 0=0x222 and addr 1=0x333, bank 0, each fb_write_en exactly 1 cycle, 1 edge after its strobe.
2. Discard word + 2048 words (64x32) -> last write addr 2047, same edge frame_ready=1, state WAIT_SWAP, no further fb_write_en.
3. In WAIT_SWAP, 300 strobes -> zero writes; overrun_count saturates at 255.
4. In WAIT_SWAP, swap_done coincident with a strobe -> overrun_count +1, bank becomes 1, frame_ready=0; next strobe writes addr 0 in bank 1.
5. swap_done pulses during WRITING, including on the last-pixel strobe cycle -> bank unchanged; frame_ready asserts normally after pixel 2047.
6. Assert reset after 100 writes in bank 1 -> all outputs at reset values; next strobe discarded; following write at addr 0, bank 0.
